// File: rtl/obuf_drain_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : obuf_drain_if
// Brief    : Output-buffer read port plus valid/ready stream toward DDR write.
// Revision : 1.0 - initial release
// ============================================================================
interface obuf_drain_if #(
    parameter int MEM_ADDR_WIDTH = 11,
    parameter int MEM_DATA_WIDTH = 64
);
    logic                      obuf_read_req;
    logic [MEM_ADDR_WIDTH-1:0] obuf_read_addr;
    logic [MEM_DATA_WIDTH-1:0] obuf_read_data;
    logic                      m_valid;
    logic                      m_ready;
    logic [MEM_DATA_WIDTH-1:0] m_data;
    logic                      m_last;

    modport master (
        output obuf_read_req,
        output obuf_read_addr,
        input  obuf_read_data,
        output m_valid,
        input  m_ready,
        output m_data,
        output m_last
    );

    modport slave (
        input  obuf_read_req,
        input  obuf_read_addr,
        output obuf_read_data,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  m_last
    );
endinterface
`default_nettype wire

// File: rtl/obuf_drain.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : obuf_drain
// Brief    : Walks an output-buffer address range, reads each word and streams
//            it out through a credit-managed return FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module obuf_drain #(
    parameter int MEM_ADDR_WIDTH = 11,
    parameter int MEM_DATA_WIDTH = 64,
    parameter int LEN_W          = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int RD_LATENCY     = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_W-1:0]          num_words,
    output logic                      busy,
    output logic                      done,
    obuf_drain_if.master              bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 2;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_READ  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [MEM_ADDR_WIDTH-1:0] c_ADDR_ONE = MEM_ADDR_WIDTH'(1);
    localparam logic [LEN_W-1:0]          c_LEN_ONE  = LEN_W'(1);
    localparam logic [CNT_W-1:0]          c_DEPTH    = CNT_W'(FIFO_DEPTH);

    logic [1:0]                r_state;
    logic [MEM_ADDR_WIDTH-1:0] r_addr_q;
    logic [LEN_W-1:0]          r_issue_cnt;
    logic [LEN_W-1:0]          r_accept_cnt;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_req;
    logic [MEM_ADDR_WIDTH-1:0] r_rd_addr;
    logic [RD_LATENCY-1:0]     r_ret_pipe;
    logic [CNT_W-1:0]          r_inflight;
    logic [PTR_W:0]            r_wr_ptr;
    logic [PTR_W:0]            r_rd_ptr;
    logic [MEM_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

    logic [PTR_W:0]            w_occ;
    logic                      w_empty;
    logic                      w_m_valid;
    logic                      w_push;
    logic                      w_pop;
    logic [CNT_W-1:0]          w_occ_next;
    logic [CNT_W-1:0]          w_infl_after;
    logic                      w_credit;
    logic                      w_start_issue;
    logic                      w_read_issue;
    logic                      w_issue;

    assign w_occ     = r_wr_ptr - r_rd_ptr;
    assign w_empty   = (w_occ == '0);
    assign w_m_valid = (r_state != c_IDLE) && !w_empty;
    assign w_push    = r_ret_pipe[RD_LATENCY-1];
    assign w_pop     = w_m_valid && bus.m_ready;

    // Credit counts every read already issued plus the one about to be issued,
    // so a returning word always finds a free FIFO slot.
    assign w_occ_next   = {1'b0, w_occ} + {{(CNT_W-1){1'b0}}, w_push}
                                        - {{(CNT_W-1){1'b0}}, w_pop};
    assign w_infl_after = r_inflight - {{(CNT_W-1){1'b0}}, w_push};
    assign w_credit     = (w_occ_next + w_infl_after) < c_DEPTH;

    assign w_start_issue = (r_state == c_IDLE) && start && (num_words != '0);
    assign w_read_issue  = (r_state == c_READ) && (r_issue_cnt != '0) && w_credit;
    assign w_issue       = w_start_issue || w_read_issue;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_addr_q     <= '0;
            r_issue_cnt  <= '0;
            r_accept_cnt <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_req        <= 1'b0;
            r_rd_addr    <= '0;
        end else begin
            r_req  <= w_issue;
            r_done <= 1'b0;
            if (w_pop) begin
                r_accept_cnt <= r_accept_cnt - c_LEN_ONE;
            end
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_busy       <= 1'b1;
                        r_accept_cnt <= num_words;
                        if (num_words == '0) begin
                            r_issue_cnt <= '0;
                            r_state     <= c_DRAIN;
                        end else begin
                            // First read goes out with busy so it lands at T+1.
                            r_rd_addr   <= base_addr;
                            r_addr_q    <= base_addr + c_ADDR_ONE;
                            r_issue_cnt <= num_words - c_LEN_ONE;
                            r_state     <= (num_words == c_LEN_ONE) ? c_DRAIN : c_READ;
                        end
                    end
                end
                c_READ: begin
                    if (w_read_issue) begin
                        r_rd_addr   <= r_addr_q;
                        r_addr_q    <= r_addr_q + c_ADDR_ONE;
                        r_issue_cnt <= r_issue_cnt - c_LEN_ONE;
                        if (r_issue_cnt == c_LEN_ONE) begin
                            r_state <= c_DRAIN;
                        end
                    end
                end
                c_DRAIN: begin
                    if ((r_accept_cnt == '0) || (w_pop && (r_accept_cnt == c_LEN_ONE))) begin
                        r_state <= c_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Return-valid pipeline mirrors the memory latency; reset drops any read in flight.
    generate
        if (RD_LATENCY == 1) begin : g_ret_lat1
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_ret_pipe <= '0;
                end else begin
                    r_ret_pipe <= r_req;
                end
            end
        end else begin : g_ret_latn
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_ret_pipe <= '0;
                end else begin
                    r_ret_pipe <= {r_ret_pipe[RD_LATENCY-2:0], r_req};
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inflight <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_inflight <= r_inflight + {{(CNT_W-1){1'b0}}, w_issue}
                                     - {{(CNT_W-1){1'b0}}, w_push};
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= bus.obuf_read_data;
        end
    end

    assign busy               = r_busy;
    assign done               = r_done;
    assign bus.obuf_read_req  = r_req;
    assign bus.obuf_read_addr = r_rd_addr;
    assign bus.m_valid        = w_m_valid;
    assign bus.m_data         = w_m_valid ? r_mem[r_rd_ptr[PTR_W-1:0]] : '0;
    assign bus.m_last         = w_m_valid && (r_accept_cnt == c_LEN_ONE);

endmodule
`default_nettype wire

// File: doc/obuf_drain.md
# obuf_drain

Read-out engine on the memory side of the output buffer. On a start command it walks a contiguous range of output-buffer memory-port addresses, issues one read per word against the buffer's 1-cycle-latency read port, and absorbs the returning data in a small credit-managed FIFO. The FIFO drives a valid/ready stream toward the DDR write path. It sits directly downstream of the output buffer and upstream of the AXI write master.

## Interface
Parameters:
- MEM_ADDR_WIDTH, 11, width of the output-buffer memory-port address (buffer address plus bank-ID bits)
- MEM_DATA_WIDTH, 64, width of one memory-port word
- LEN_W, 16, width of the word-count field
- FIFO_DEPTH, 4, return-data FIFO entries; power of two, at least 2
- RD_LATENCY, 1, cycles from `obuf_read_req` to valid `obuf_read_data`; fixed at 1 in this revision

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle command pulse; sampled only in IDLE
- base_addr  in  MEM_ADDR_WIDTH  first read address
- num_words  in  LEN_W  number of words to read
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse when the last word has been accepted downstream
- obuf_read_req  out  1  read strobe to the output-buffer memory port
- obuf_read_addr  out  MEM_ADDR_WIDTH  read address
- obuf_read_data  in  MEM_DATA_WIDTH  read data, valid RD_LATENCY cycles after the request
- m_valid  out  1  stream data valid
- m_ready  in  1  stream consumer ready
- m_data  out  MEM_DATA_WIDTH  stream data
- m_last  out  1  high with the final word of the command

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE: busy=0. On `start`, latch base_addr into addr_q and num_words into issue_cnt and accept_cnt.
  - If num_words==0, go to DONE.
  - Otherwise go to READ.
- READ: assert `obuf_read_req` with `obuf_read_addr`=addr_q whenever `issue_cnt>0` and `occupancy+inflight < FIFO_DEPTH`.
  - occupancy is the FIFO fill level; inflight is the count of reads issued but not yet returned (0 or 1).
  - Each issue increments addr_q, wrapping modulo 2^MEM_ADDR_WIDTH, and decrements issue_cnt.
  - When issue_cnt reaches 0, go to DRAIN.
- Read return: the cycle after a request, push `obuf_read_data` into the FIFO.
  - The credit rule above guarantees the push never finds the FIFO full.
- DRAIN: no new reads issued. Stay until accept_cnt reaches 0, then go to DONE.
- Stream side, in every non-IDLE state:
  - m_valid = FIFO not empty; m_data = FIFO head.
  - On a transfer (m_valid && m_ready): pop the FIFO and decrement accept_cnt.
  - m_last = m_valid && accept_cnt==1.
- DONE: pulse done for one cycle, then go to IDLE.
- A push and a pop in the same cycle leave occupancy unchanged. Simultaneous full and push cannot occur.
- `start` outside IDLE is ignored; latched parameters are not altered.
- Reset:
  - State goes to IDLE; FIFO pointers and all counters clear.
  - An in-flight read returning the cycle after reset is discarded, not pushed.
- Reset values: busy=0, done=0, obuf_read_req=0, obuf_read_addr=0, m_valid=0, m_data=0, m_last=0.

## Timing
- All outputs are registered except m_valid, m_data and m_last, which are decoded from the FIFO head and accept_cnt.
- start at cycle T: busy=1 and the first `obuf_read_req` at T+1. Data reaches the FIFO at T+2, and m_valid rises at T+3 (FIFO write is registered).
- With m_ready held high, sustained throughput is 1 word/cycle after the first. N words finish with done at T+N+3.
- done asserts the cycle after the final transfer; busy falls in the same cycle done asserts.
- m_data must stay stable while m_valid && !m_ready.
- obuf_read_addr holds its last value when obuf_read_req=0.

## Test plan
- Basic: base_addr=0x010, num_words=8, m_ready=1 → reads at 0x010..0x017 on 8 consecutive cycles; 8 words out in order; m_last on word 8; done at T+11.
- Backpressure: num_words=16 with m_ready toggling 1-of-3 cycles → never more than FIFO_DEPTH words outstanding plus buffered; no loss or duplication; m_data stable while stalled.
- Wrap: base_addr=0x7FE, num_words=4 → read addresses 0x7FE, 0x7FF, 0x000, 0x001.
- Zero length: num_words=0 → no obuf_read_req; done pulses at T+2; busy high for exactly one cycle.
- Restart and ignore: a second start mid-command is ignored; a start in the cycle after done is accepted.
- Reset mid-op: reset during READ with one read in flight → next cycle all outputs at reset values, returning data not emitted; a following 2-word command completes correctly.
